// File: rtl/except_arbiter.sv
// MEM-stage exception arbiter: prioritises exceptions and interrupts for CP0,
// requests the pipeline flush/redirect, synchronises interrupt lines and counts exceptions.
module except_arbiter #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid_i,
    input  logic [31:0]      inst_addr_i,
    input  logic             is_in_delayslot_i,
    input  logic [4:0]       exc_flags_i,
    input  logic [31:0]      cp0_status_i,
    input  logic [31:0]      cp0_cause_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             wb_cp0_we_i,
    input  logic [4:0]       wb_cp0_waddr_i,
    input  logic [31:0]      wb_cp0_data_i,
    input  logic [5:0]       ext_int_i,
    output logic [5:0]       int_sync_o,
    output logic [31:0]      excepttype_o,
    output logic [31:0]      except_addr_o,
    output logic             except_delayslot_o,
    output logic             flush_o,
    output logic [31:0]      new_pc_o,
    output logic [CNT_W-1:0] exc_count_o
);

    localparam logic [0:0]  RUN        = 1'b0;
    localparam logic [0:0]  SQUASH     = 1'b1;
    localparam logic [31:0] CODE_INT   = 32'h0000_0001;
    localparam logic [31:0] CODE_SYS   = 32'h0000_0008;
    localparam logic [31:0] CODE_RI    = 32'h0000_000a;
    localparam logic [31:0] CODE_TRAP  = 32'h0000_000d;
    localparam logic [31:0] CODE_OV    = 32'h0000_000c;
    localparam logic [31:0] CODE_ERET  = 32'h0000_000e;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [5:0]       sync1_q, sync2_q;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] status_f, cause_f, epc_f;
    logic        int_req;
    logic [31:0] code;
    logic        flush;

    // CP0 values as they will be once the in-flight WB mtc0 lands
    always_comb begin
        status_f = cp0_status_i;
        cause_f  = cp0_cause_i;
        epc_f    = cp0_epc_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd12) status_f = wb_cp0_data_i;
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd13)
            cause_f = {cp0_cause_i[31:10], wb_cp0_data_i[9:8], cp0_cause_i[7:0]};
        if (wb_cp0_we_i && wb_cp0_waddr_i == 5'd14) epc_f = wb_cp0_data_i;
    end

    assign int_req = (|(cause_f[15:8] & status_f[15:8])) & status_f[0] & ~status_f[1];

    // Priority select; SQUASH hides the instruction being flushed
    always_comb begin
        code = 32'h0;
        if (!rst && inst_valid_i && state_q == RUN) begin
            if (int_req)             code = CODE_INT;
            else if (exc_flags_i[0]) code = CODE_SYS;
            else if (exc_flags_i[1]) code = CODE_RI;
            else if (exc_flags_i[2]) code = CODE_TRAP;
            else if (exc_flags_i[3]) code = CODE_OV;
            else if (exc_flags_i[4]) code = CODE_ERET;
        end
    end

    assign flush = (code != 32'h0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            RUN:     if (flush) state_d = SQUASH;
            SQUASH:  state_d = RUN;
            default: state_d = RUN;
        endcase
        if (flush && code != CODE_ERET && count_q != CNT_MAX)
            count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            sync1_q <= 6'h0;
            sync2_q <= 6'h0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= ext_int_i;
            sync2_q <= sync1_q;
            count_q <= count_d;
        end
    end

    assign int_sync_o         = sync2_q;
    assign excepttype_o       = code;
    assign flush_o            = flush;
    assign new_pc_o           = !flush ? 32'h0 : (code == CODE_ERET ? epc_f : EXC_VECTOR);
    assign except_addr_o      = inst_addr_i;
    assign except_delayslot_o = is_in_delayslot_i;
    assign exc_count_o        = count_q;

endmodule
